regfile_scoreboard: RTL

//  Parametrised integer register file for the pipelined RISC-V core, with an integrated per-register

---
 rtl/regfile_scoreboard.sv | 97 +++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register pending-write counters for decode hazard checks.
// Latency: reads and hazard/ready outputs are combinational; writes and counters update on clk.
// Backpressure: issue_ready drops while the destination's counter is saturated (unless it retires now).
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int CNTW   = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            busy1,
  output logic            busy2,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic [AW-1:0]   A3,
  input  logic            WE3,
  input  logic [XLEN-1:0] WD3,
  input  logic            flush
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [XLEN-1:0] regs [NREG];
  logic [CNTW-1:0] cnt  [NREG];

  logic ret;
  logic acc;
  logic hit1;
  logic hit2;

  // Index 0 and indices past the implemented registers hold nothing.
  function automatic logic valid_idx(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREG);
  endfunction

  function automatic logic [CNTW-1:0] cnt_of(input logic [AW-1:0] a);
    return valid_idx(a) ? cnt[a] : '0;
  endfunction

  function automatic logic [XLEN-1:0] rd_of(input logic [AW-1:0] a);
    if (!valid_idx(a))
      return '0;
    else if (BYPASS && WE3 && (A3 == a))
      return WD3;
    else
      return regs[a];
  endfunction

  assign RD1 = rd_of(A1);
  assign RD2 = rd_of(A2);

  assign ret = WE3 && valid_idx(A3) && (cnt_of(A3) != '0);

  assign issue_ready = (issue_rd == '0) || (cnt_of(issue_rd) != CNT_MAX) ||
                       (ret && (A3 == issue_rd));

  assign acc = issue_valid && issue_ready && !flush && valid_idx(issue_rd);

  // A write landing this cycle satisfies one pending write when it is forwarded.
  assign hit1 = BYPASS && WE3 && (A3 == A1);
  assign hit2 = BYPASS && WE3 && (A3 == A2);

  assign busy1 = (A1 != '0) && (cnt_of(A1) > CNTW'(hit1));
  assign busy2 = (A2 != '0) && (cnt_of(A2) > CNTW'(hit2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (WE3 && valid_idx(A3)) begin
      regs[A3] <= WD3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < NREG; i++) begin
        if (flush)
          cnt[i] <= '0;
        else if (acc && (issue_rd == AW'(i)) && !(ret && (A3 == AW'(i))))
          cnt[i] <= cnt[i] + 1'b1;
        else if (ret && (A3 == AW'(i)) && !(acc && (issue_rd == AW'(i))))
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

endmodule
